// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard/control signals between the pipeline datapath and pipeline_ctrl.
// master = the controller (drives enables/flushes/redirects), slave = the datapath.
interface pipeline_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic [4:0]  ex_rd;
  logic        ex_w_en;
  logic        ex_is_load;
  logic [4:0]  dm_rd;
  logic        dm_w_en;
  logic        branch_taken;
  logic        mem_busy;
  logic        wb_halt;
  logic        resume;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_dm_en;
  logic        dm_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic [1:0]  redir_a;
  logic [1:0]  redir_b;
  logic        halted;
  logic [31:0] stall_cnt;

  modport master (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  ex_rd, ex_w_en, ex_is_load, dm_rd, dm_w_en,
    input  branch_taken, mem_busy, wb_halt, resume,
    output pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en,
    output if_id_flush, id_ex_flush, redir_a, redir_b,
    output halted, stall_cnt
  );

  modport slave (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output ex_rd, ex_w_en, ex_is_load, dm_rd, dm_w_en,
    output branch_taken, mem_busy, wb_halt, resume,
    input  pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en,
    input  if_id_flush, id_ex_flush, redir_a, redir_b,
    input  halted, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard/stall controller: RUN/FREEZE/HALTED/RESUME FSM plus stall counter.
// Define FORWARD_EN for operand forwarding with load-use stalls; otherwise every RAW match stalls.
module pipeline_ctrl (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    HALTED = 2'd2,
    RESUME = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] stall_cnt_reg;

  logic [1:0][4:0] src;
  logic [1:0]      use_src;
  logic [1:0]      match_ex;
  logic [1:0]      match_dm;
  logic [1:0][1:0] redir;
  logic            ex_valid;
  logic            dm_valid;
  logic            hazard;

  // enable order: {pc, if_id, id_ex, ex_dm, dm_wb}; flush order: {if_id, id_ex}
  logic [4:0] run_en;
  logic [1:0] run_flush;
  logic [4:0] en_vec;
  logic [1:0] flush_vec;

  assign src[0]     = bus.id_rs;
  assign src[1]     = bus.id_rt;
  assign use_src[0] = bus.id_use_rs;
  assign use_src[1] = bus.id_use_rt;

  // Register 0 is hard-wired zero, so it can never be a producer.
  assign ex_valid = bus.ex_w_en && (bus.ex_rd != 5'd0);
  assign dm_valid = bus.dm_w_en && (bus.dm_rd != 5'd0);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign match_ex[gi] = ex_valid && (bus.ex_rd == src[gi]);
      assign match_dm[gi] = dm_valid && (bus.dm_rd == src[gi]);
`ifdef FORWARD_EN
      // The younger producer (EX_DM) holds the newer value, so it wins.
      assign redir[gi] = match_ex[gi] ? 2'b01 :
                         match_dm[gi] ? 2'b10 : 2'b00;
`else
      assign redir[gi] = 2'b00;
`endif
    end
  endgenerate

`ifdef FORWARD_EN
  // Only a load in EX cannot be forwarded in time; its data appears a stage later.
  assign hazard = bus.ex_is_load && |(match_ex & use_src);
`else
  assign hazard = |((match_ex | match_dm) & use_src);
`endif

  // Response for an unfrozen cycle; a branch squashes the hazarding instruction anyway.
  always_comb begin
    run_en    = 5'b11111;
    run_flush = 2'b00;
    if (bus.branch_taken) begin
      run_flush = 2'b11;
    end else if (hazard) begin
      run_en    = 5'b00111;
      run_flush = 2'b01;
    end
  end

  // Leaving FREEZE, the cycle where mem_busy drops already behaves as RUN so a
  // busy window of N cycles costs exactly N frozen cycles.
  always_comb begin
    state_next = state_reg;
    en_vec     = 5'b00000;
    flush_vec  = 2'b00;
    unique case (state_reg)
      RUN: begin
        if (bus.wb_halt) begin
          state_next = HALTED;
        end else if (bus.mem_busy) begin
          state_next = FREEZE;
        end else begin
          en_vec    = run_en;
          flush_vec = run_flush;
        end
      end
      FREEZE: begin
        if (!bus.mem_busy) begin
          state_next = RUN;
          en_vec     = run_en;
          flush_vec  = run_flush;
        end
      end
      HALTED: begin
        if (bus.resume) begin
          state_next = RESUME;
        end
      end
      RESUME: begin
        // The halt flag is still in DM_WB this cycle; let it drain without re-halting.
        state_next = RUN;
        en_vec     = 5'b11111;
      end
      default: begin
        state_next = RUN;
      end
    endcase
    if (!rst) begin
      state_next = RUN;
      en_vec     = 5'b00000;
      flush_vec  = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= 32'd0;
    end else if (!en_vec[4] && (state_reg != HALTED) && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign bus.pc_en       = en_vec[4];
  assign bus.if_id_en    = en_vec[3];
  assign bus.id_ex_en    = en_vec[2];
  assign bus.ex_dm_en    = en_vec[1];
  assign bus.dm_wb_en    = en_vec[0];
  assign bus.if_id_flush = flush_vec[1];
  assign bus.id_ex_flush = flush_vec[0];
  assign bus.redir_a     = rst ? redir[0] : 2'b00;
  assign bus.redir_b     = rst ? redir[1] : 2'b00;
  assign bus.halted      = rst && (state_reg == HALTED);
  assign bus.stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl; expected values are hand-derived per scenario.
// Covers both the FORWARD_EN build and the default all-stall build.
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_stall;

  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] en_obs;
  logic [1:0] fl_obs;
  assign en_obs = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_dm_en, bus.dm_wb_en};
  assign fl_obs = {bus.if_id_flush, bus.id_ex_flush};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic clear_inputs();
    bus.id_rs        = 5'd0;
    bus.id_rt        = 5'd0;
    bus.id_use_rs    = 1'b0;
    bus.id_use_rt    = 1'b0;
    bus.ex_rd        = 5'd0;
    bus.ex_w_en      = 1'b0;
    bus.ex_is_load   = 1'b0;
    bus.dm_rd        = 5'd0;
    bus.dm_w_en      = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_busy     = 1'b0;
    bus.wb_halt      = 1'b0;
    bus.resume       = 1'b0;
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_stall = 0;
    rst       = 1'b0;
    clear_inputs();

    // Reset: outputs forced inactive even with a branch and a matching producer present.
    bus.branch_taken = 1'b1;
    bus.ex_rd = 5'd3; bus.ex_w_en = 1'b1; bus.id_rs = 5'd3; bus.id_use_rs = 1'b1;
    #3;
    chk("rst_en", 32'(en_obs), 32'h00);
    chk("rst_flush", 32'(fl_obs), 32'h0);
    chk("rst_redir_a", 32'(bus.redir_a), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_stall", bus.stall_cnt, 32'd0);
    tick(); tick();
    rst = 1'b1;
    clear_inputs();

    // Idle RUN
    #1;
    chk("idle_en", 32'(en_obs), 32'h1F);
    chk("idle_flush", 32'(fl_obs), 32'h0);
    tick();

    // Branch alone
    bus.branch_taken = 1'b1;
    #1;
    chk("br_en", 32'(en_obs), 32'h1F);
    chk("br_flush", 32'(fl_obs), 32'h3);
    tick(); clear_inputs();

    // Load r5 in EX, ID reads r5 through rs
    bus.ex_rd = 5'd5; bus.ex_w_en = 1'b1; bus.ex_is_load = 1'b1;
    bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
    #1;
    chk("lu_en", 32'(en_obs), 32'h07);
    chk("lu_flush", 32'(fl_obs), 32'h1);
    tick(); exp_stall++;
    bus.ex_rd = 5'd0; bus.ex_w_en = 1'b0; bus.ex_is_load = 1'b0;
    bus.dm_rd = 5'd5; bus.dm_w_en = 1'b1;
    #1;
    chk("lu_stall1", bus.stall_cnt, 32'(exp_stall));
`ifdef FORWARD_EN
    chk("lu_next_en", 32'(en_obs), 32'h1F);
    chk("lu_next_redir_a", 32'(bus.redir_a), 32'h2);
    tick(); clear_inputs();
`else
    chk("lu_dm_en", 32'(en_obs), 32'h07);
    chk("lu_dm_redir_a", 32'(bus.redir_a), 32'h0);
    tick(); exp_stall++; clear_inputs();
`endif
    #1;
    chk("lu_after_en", 32'(en_obs), 32'h1F);
    chk("lu_after_stall", bus.stall_cnt, 32'(exp_stall));

    // Load in EX but source not actually read, and register 0 producers
    bus.ex_rd = 5'd5; bus.ex_w_en = 1'b1; bus.ex_is_load = 1'b1;
    bus.id_rs = 5'd5; bus.id_use_rs = 1'b0;
    #1;
    chk("nouse_en", 32'(en_obs), 32'h1F);
    bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_use_rs = 1'b1;
    bus.dm_rd = 5'd0; bus.dm_w_en = 1'b1; bus.id_rt = 5'd0; bus.id_use_rt = 1'b1;
    #1;
    chk("r0_en", 32'(en_obs), 32'h1F);
    chk("r0_redir_a", 32'(bus.redir_a), 32'h0);
    chk("r0_redir_b", 32'(bus.redir_b), 32'h0);
    tick(); clear_inputs();

`ifdef FORWARD_EN
    // ALU r3 forwarding via rt
    bus.ex_rd = 5'd3; bus.ex_w_en = 1'b1; bus.id_rt = 5'd3; bus.id_use_rt = 1'b1;
    #1;
    chk("fw_ex_en", 32'(en_obs), 32'h1F);
    chk("fw_ex_redir_b", 32'(bus.redir_b), 32'h1);
    bus.ex_w_en = 1'b0; bus.dm_rd = 5'd3; bus.dm_w_en = 1'b1;
    #1;
    chk("fw_dm_redir_b", 32'(bus.redir_b), 32'h2);
    bus.ex_w_en = 1'b1;
    #1;
    chk("fw_both_redir_b", 32'(bus.redir_b), 32'h1);
    chk("fw_both_redir_a", 32'(bus.redir_a), 32'h0);
    tick(); clear_inputs();
`else
    // ALU r7 in EX, ID reads r7: stalls while the producer is in EX then DM
    bus.ex_rd = 5'd7; bus.ex_w_en = 1'b1; bus.id_rs = 5'd7; bus.id_use_rs = 1'b1;
    #1;
    chk("ns_ex_en", 32'(en_obs), 32'h07);
    chk("ns_ex_flush", 32'(fl_obs), 32'h1);
    chk("ns_ex_redir_a", 32'(bus.redir_a), 32'h0);
    tick(); exp_stall++;
    bus.ex_rd = 5'd0; bus.ex_w_en = 1'b0; bus.dm_rd = 5'd7; bus.dm_w_en = 1'b1;
    #1;
    chk("ns_dm_en", 32'(en_obs), 32'h07);
    chk("ns_dm_redir_a", 32'(bus.redir_a), 32'h0);
    tick(); exp_stall++; clear_inputs();
    #1;
    chk("ns_after_en", 32'(en_obs), 32'h1F);
    chk("ns_after_stall", bus.stall_cnt, 32'(exp_stall));
`endif

    // Branch together with a load-use match: branch response only
    bus.ex_rd = 5'd9; bus.ex_w_en = 1'b1; bus.ex_is_load = 1'b1;
    bus.id_rt = 5'd9; bus.id_use_rt = 1'b1; bus.branch_taken = 1'b1;
    #1;
    chk("brlu_en", 32'(en_obs), 32'h1F);
    chk("brlu_flush", 32'(fl_obs), 32'h3);
    tick(); clear_inputs();
    chk("brlu_stall", bus.stall_cnt, 32'(exp_stall));

    // mem_busy for 4 cycles; branch and wb_halt during the window are overridden/ignored
    for (int i = 0; i < 4; i++) begin
      bus.mem_busy     = 1'b1;
      bus.branch_taken = (i == 0);
      bus.wb_halt      = (i == 2);
      #1;
      chk($sformatf("busy%0d_en", i), 32'(en_obs), 32'h00);
      chk($sformatf("busy%0d_flush", i), 32'(fl_obs), 32'h0);
      tick(); exp_stall++;
    end
    clear_inputs();
    #1;
    chk("busy_exit_en", 32'(en_obs), 32'h1F);
    chk("busy_exit_halted", 32'(bus.halted), 32'h0);
    chk("busy_exit_stall", bus.stall_cnt, 32'(exp_stall));
    tick();
    chk("busy_run_stall", bus.stall_cnt, 32'(exp_stall));

    // Halt, resume, drain of the stale halt flag
    bus.wb_halt = 1'b1;
    #1;
    chk("halt_req_en", 32'(en_obs), 32'h00);
    tick(); exp_stall++;
    bus.mem_busy = 1'b1;
    #1;
    chk("halted_flag", 32'(bus.halted), 32'h1);
    chk("halted_en", 32'(en_obs), 32'h00);
    chk("halted_stall", bus.stall_cnt, 32'(exp_stall));
    tick(); tick();
    bus.mem_busy = 1'b0; bus.resume = 1'b1;
    #1;
    chk("resume_req_en", 32'(en_obs), 32'h00);
    chk("hold_stall", bus.stall_cnt, 32'(exp_stall));
    tick();
    bus.resume = 1'b0;
    #1;
    chk("resume_en", 32'(en_obs), 32'h1F);
    chk("resume_halted", 32'(bus.halted), 32'h0);
    tick();
    bus.wb_halt = 1'b0;
    #1;
    chk("post_resume_en", 32'(en_obs), 32'h1F);
    chk("post_resume_halted", 32'(bus.halted), 32'h0);
    chk("post_resume_stall", bus.stall_cnt, 32'(exp_stall));
    tick();

    // Reset asserted mid-FREEZE
    bus.mem_busy = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_freeze_en", 32'(en_obs), 32'h00);
    chk("rst_freeze_stall", bus.stall_cnt, 32'd0);
    tick();
    bus.mem_busy = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_freeze_run_en", 32'(en_obs), 32'h1F);

    // Reset asserted while HALTED
    tick();
    bus.wb_halt = 1'b1;
    tick();
    bus.wb_halt = 1'b0;
    #1;
    chk("pre_rst_halted", 32'(bus.halted), 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_halt_halted", 32'(bus.halted), 32'h0);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_halt_run_en", 32'(en_obs), 32'h1F);
    chk("rst_halt_stall", bus.stall_cnt, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
